// File: rtl/booth_multiplier_param.sv
// -----------------------------------------------------------------------------
// booth_multiplier_param
//
// Sequential radix-2 Booth multiplier with selectable signed/unsigned operands,
// a start/busy/done handshake and a synchronous abort. One Booth step is taken
// per clock, so a multiply takes exactly WIDTH+1 cycles.
//
// The operands are extended to WIDTH+1 bits. Signed mode sign-extends them and
// unsigned mode zero-extends them. This lets one signed Booth core handle both
// modes exactly. It also keeps the accumulator from overflowing on the
// most-negative operand.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request; only accepted in IDLE or DONE
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   clear      synchronous abort back to IDLE; has priority over start
//   operand_a  multiplicand (sampled with start)
//   operand_b  multiplier   (sampled with start)
//   busy       high while the multiply is iterating
//   done       one-cycle pulse when hi/lo have just been updated
//   hi, lo     upper / lower halves of the last completed product
// -----------------------------------------------------------------------------
module booth_multiplier_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             clear,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W1 = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W1-1:0]   m_reg;      // extended multiplicand
  logic [2*W1-1:0] prod_reg;   // {accumulator, multiplier/low product}
  logic            lost_reg;   // bit shifted out on the previous step
  logic [CNT_W-1:0] cnt_reg;

  // The extension bit is the operand MSB in signed mode and zero in unsigned mode.
  logic [W1-1:0] ext_a;
  logic [W1-1:0] ext_b;
  assign ext_a = {is_signed & operand_a[WIDTH-1], operand_a};
  assign ext_b = {is_signed & operand_b[WIDTH-1], operand_b};

  // One Booth step: add or subtract M into the upper half, then shift the
  // whole product right arithmetically.
  logic [W1-1:0]   upper;
  logic [W1-1:0]   sum;
  logic [2*W1-1:0] prod_next;

  always_comb begin
    upper = prod_reg[2*W1-1:W1];
    sum   = upper;
    case ({prod_reg[0], lost_reg})
      2'b01:   sum = upper + m_reg;
      2'b10:   sum = upper - m_reg;
      default: sum = upper;
    endcase
    prod_next = {sum[W1-1], sum, prod_reg[W1-1:1]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      prod_reg  <= '0;
      lost_reg  <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (clear) begin
      // An abort leaves the last completed result visible on hi/lo.
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            m_reg     <= ext_a;
            prod_reg  <= {{W1{1'b0}}, ext_b};
            lost_reg  <= 1'b0;
            cnt_reg   <= CNT_INIT;
            busy      <= 1'b1;
            done      <= 1'b0;
            state_reg <= RUN;
          end else begin
            done      <= 1'b0;
            state_reg <= IDLE;
          end
        end

        RUN: begin
          prod_reg <= prod_next;
          lost_reg <= prod_reg[0];
          cnt_reg  <= cnt_reg - CNT_LAST;
          // On the last step, publish the post-shift product directly so that
          // hi/lo and done become valid on the same edge.
          if (cnt_reg == CNT_LAST) begin
            hi        <= prod_next[2*WIDTH-1:WIDTH];
            lo        <= prod_next[WIDTH-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end
        end

        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_multiplier_param.md
Name: booth_multiplier_param

Overview:
- Parametrised sequential radix-2 Booth multiplier, the next generation of the datapath's 32x32 multiplier.
- Adds selectable signed/unsigned mode, a start/busy/done handshake, synchronous abort, and result registers that update only on completion.
- Sits beside the ALU and feeds the hi/lo registers for mult/multu, plus any narrower multiply users via WIDTH.

Parameters:
- WIDTH, 32, operand width in bits (>=2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+2), width of the internal iteration counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE and DONE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- clear  in  1  synchronous abort; returns to IDLE
- operand_a  in  WIDTH  multiplicand; sampled with start
- operand_b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, result valid
- hi  out  WIDTH  upper half of product
- lo  out  WIDTH  lower half of product

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal product and lost-bit registers = 0.
- States: IDLE, RUN, DONE.
- Internal width is W1 = WIDTH+1. Operands are extended by one bit: sign-extended if is_signed=1, zero-extended otherwise. This makes unsigned operation exact with the same Booth core.
- IDLE, start=1: latch the extended operand_a as M, product = {W1 zeros, extended operand_b}, lost bit = 0, counter = W1, go to RUN, busy=1.
- IDLE, start=0: hold. hi/lo keep their last value.
- RUN, each cycle, using {product[0], lost bit}:
  - 01: upper W1 bits += M.
  - 10: upper W1 bits -= M.
  - 00/11: no add.
  - Then lost bit = product[0], arithmetic shift right by 1 (MSB replicated), counter -= 1.
  - Adds and subtracts are modulo 2^W1.
- RUN, counter reaches 0 on this edge: load hi = product[2*WIDTH-1:WIDTH] and lo = product[WIDTH-1:0] (after the final shift), done=1, busy=0, go to DONE.
- Latency: start sampled at edge k → done=1 and hi/lo valid after edge k+W1 (33 cycles for WIDTH=32).
- DONE, one cycle only, done=1:
  - start=1: accept a new request exactly as from IDLE (back-to-back; done drops, busy rises on the same edge).
  - Otherwise go to IDLE, done=0.
- hi/lo hold the last completed result until the next completion. They never show intermediate values.
- start while in RUN is ignored. There is no queuing.
- Operand or is_signed changes during RUN have no effect, because they are latched.
- clear=1 has priority over start in every state. It forces IDLE, busy=0, done=0 and counter=0, and leaves hi/lo unchanged. An aborted operation never pulses done.
- reset=0 mid-operation: immediate return to the reset values above. After reset deasserts, the block waits in IDLE.
- Zero operands still take the full W1 cycles. There is no early termination, so latency is deterministic.
- Most-negative operands (e.g. 0x80000000 x 0x80000000 signed) must produce the exact 2*WIDTH-bit result. The extra internal bit prevents overflow of the accumulator.

Test Plan:
- WIDTH=32, signed, a=7, b=-3 → done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- WIDTH=32, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. The same operands with is_signed=1 → hi=0, lo=1.
- WIDTH=32, signed, a=b=0x80000000 → hi=0x40000000, lo=0. Then a second start in the DONE cycle with a=3, b=5 → done 33 cycles later, hi=0, lo=15, with no idle gap.
- Start a=100, b=200, then pulse clear at cycle 10 → busy=0 next cycle, no done pulse, hi/lo retain the previous result. Toggling start during RUN of another operation is ignored, and the result is unchanged.
- Assert reset low at cycle 20 of an operation → hi=lo=0, busy=done=0 immediately (without a clock edge). The next start produces the correct product.
- WIDTH=8, random signed and unsigned sweep of 1000 pairs → {hi,lo} equals the reference product; done arrives exactly 9 cycles after each start.
